button_debounce: RTL and testbench
==================================

Name: button_debounce

Overview:
- Cleans a raw, bouncing, asynchronous push-button input into a glitch-free, clock-synchronous level.
- Sits directly upstream of the one-pulse generator: debounced level drives its in_trig input.
- Also flags a long press (button held beyond a programmable time) for mode/clear functions in lab top levels.

Parameters:
- STABLE_CYCLES, 400000, consecutive clk cycles the synchronized input must hold a new value before the debounced level changes (10 ms at 40 MHz); legal range >= 2.
- CNT_W, 19, width of stability counter; must satisfy 2^CNT_W > STABLE_CYCLES.
- HOLD_CYCLES, 40000000, cycles in committed-pressed state before long_press asserts (1 s at 40 MHz); legal range >= 2.
- HOLD_W, 26, width of hold counter; must satisfy 2^HOLD_W > HOLD_CYCLES.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset; one clock; reset is asynchronous and active-high.
- btn_raw  input  1  raw button, active-high pressed, asynchronous to clk, may bounce.
- btn_level  output  1  debounced level, 1 = pressed; registered.
- long_press  output  1  1 while committed press has lasted >= HOLD_CYCLES; registered.

Behaviour:
- Reset (async, rst=1): sync flops s1,s2=0; state=IDLE; stability and hold counters=0; btn_level=0; long_press=0. Release is synchronous to next clk edge. Reset mid-debounce or mid-hold discards all progress.
- Synchronizer: two flops, s1<=btn_raw, s2<=s1; FSM sees only s2 ("in_sync").
- States: IDLE (released, btn_level=0), WAIT_P (candidate press), PRESSED (btn_level=1), WAIT_R (candidate release, btn_level still 1).
- IDLE: in_sync=1 -> WAIT_P, cnt<=0.
- WAIT_P: in_sync=0 -> IDLE (bounce rejected, cnt cleared); else cnt==STABLE_CYCLES-1 -> PRESSED, hold<=0; else cnt<=cnt+1.
- PRESSED: in_sync=0 -> WAIT_R, cnt<=0; hold counter keeps running in same cycle per rule below.
- WAIT_R: in_sync=1 -> PRESSED (bounce rejected; hold counter NOT cleared, long_press unchanged); else cnt==STABLE_CYCLES-1 -> IDLE, long_press<=0, hold<=0; else cnt<=cnt+1.
- btn_level is 1 exactly in PRESSED and WAIT_R (Moore, decoded from state register, no combinational path from btn_raw).
- Latency: clean edge on btn_raw sampled at edge E1 -> btn_level changes at edge E(STABLE_CYCLES+3). Same for release.
- Hold counter: increments every cycle in PRESSED or WAIT_R; when hold==HOLD_CYCLES-1, long_press<=1 next edge and counter saturates (no wrap). long_press cleared only on release commit or reset.
- Any in_sync mismatch during WAIT_* restarts the full STABLE_CYCLES window; a glitch shorter than STABLE_CYCLES never changes btn_level.
- Counters never wrap; widths checked against parameters by design rules above.

Test Plan:
(params STABLE_CYCLES=4, CNT_W=3, HOLD_CYCLES=10, HOLD_W=4 for bench)
- Reset: assert rst mid-clock with btn_raw=1 -> btn_level=0, long_press=0 immediately, held while rst=1.
- Clean press: btn_raw 0->1 before edge E1, held -> btn_level rises at E7, not before; clean release -> falls 7 edges after sampling.
- Bounce reject: btn_raw toggles 1,0,1,0 every 2 cycles, then 0 -> btn_level stays 0 throughout; 3-cycle high pulse -> stays 0; 4+ cycles stable after sync -> rises.
- Release bounce: while pressed, btn_raw low for 2 cycles then high -> btn_level stays 1, long_press timing unaffected.
- Long press: hold btn_raw=1 -> long_press asserts 10 edges after btn_level rises, stays 1 (no wrap) for 50 cycles; release -> long_press and btn_level fall on same edge.
- Reset mid-WAIT_P (cnt=2) then release rst with btn_raw=1 -> full 4-cycle window restarts after resync; btn_level rises at edge 7 after reset release.

Source files
------------

// File: rtl/button_debounce.sv
// Push-button conditioner: two-flop synchronizer, four-state debounce FSM and
// a saturating hold timer that flags a long press.
module button_debounce #(
  parameter int STABLE_CYCLES = 400000,
  parameter int CNT_W         = 19,
  parameter int HOLD_CYCLES   = 40000000,
  parameter int HOLD_W        = 26
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_level,
  output logic long_press
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    WAIT_P  = 2'b01,
    PRESSED = 2'b11,
    WAIT_R  = 2'b10
  } state_t;

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  state_t              state, state_nxt;
  logic                s1, in_sync;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic [HOLD_W-1:0]   hold, hold_nxt;
  logic                long_nxt;

  // Two-flop synchronizer; nothing downstream ever looks at btn_raw directly.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1      <= 1'b0;
      in_sync <= 1'b0;
    end else begin
      s1      <= btn_raw;
      in_sync <= s1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      hold       <= '0;
      long_press <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      hold       <= hold_nxt;
      long_press <= long_nxt;
    end
  end

  // NOTE: every combinational output gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    hold_nxt  = hold;
    long_nxt  = long_press;

    // Hold timer runs through release bounces and saturates at its last value.
    if (state == PRESSED || state == WAIT_R) begin
      if (hold == HOLD_LAST) long_nxt = 1'b1;
      else                   hold_nxt = hold + HOLD_W'(1);
    end

    case (state)
      IDLE: begin
        if (in_sync) begin
          state_nxt = WAIT_P;
          cnt_nxt   = '0;
        end
      end
      WAIT_P: begin
        if (!in_sync) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = PRESSED;
          hold_nxt  = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      PRESSED: begin
        if (!in_sync) begin
          state_nxt = WAIT_R;
          cnt_nxt   = '0;
        end
      end
      WAIT_R: begin
        if (in_sync) begin
          state_nxt = PRESSED;
        end else if (cnt == CNT_LAST) begin
          state_nxt = IDLE;
          long_nxt  = 1'b0;
          hold_nxt  = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    btn_level = (state == PRESSED) || (state == WAIT_R);
  end

endmodule

// File: tb/tb_button_debounce.sv
// Bench for button_debounce: a run-length reference model checked every cycle,
// plus hand-timed literal expectations for press, release, bounce and reset.
module tb_button_debounce;

  localparam int STABLE_CYCLES = 4;
  localparam int CNT_W         = 3;
  localparam int HOLD_CYCLES   = 10;
  localparam int HOLD_W        = 4;

  logic clk = 1'b0;
  logic rst;
  logic btn_raw;
  logic btn_level;
  logic long_press;

  int n_pass  = 0;
  int n_total = 0;

  button_debounce #(
    .STABLE_CYCLES(STABLE_CYCLES),
    .CNT_W        (CNT_W),
    .HOLD_CYCLES  (HOLD_CYCLES),
    .HOLD_W       (HOLD_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_raw   (btn_raw),
    .btn_level (btn_level),
    .long_press(long_press)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic actual, input logic expected);
    n_total++;
    if (actual === expected) n_pass++;
    else $display("FAIL %s: got %b, expected %b at %0t", name, actual, expected, $time);
  endtask

  // Reference model: the input seen by the debouncer is btn_raw delayed two
  // edges; the level flips once STABLE_CYCLES+1 consecutive samples disagree
  // with it; long press is true once the level has been high HOLD_CYCLES edges.
  logic m_d1, m_d2, m_level, m_long;
  int   m_run, m_hold;

  always @(posedge clk or posedge rst) begin
    logic seen;
    if (rst) begin
      m_d1 = 1'b0; m_d2 = 1'b0; m_level = 1'b0; m_long = 1'b0;
      m_run = 0; m_hold = 0;
    end else begin
      seen = m_d2;
      m_d2 = m_d1;
      m_d1 = btn_raw;
      if (seen != m_level) begin
        m_run++;
        if (m_run == STABLE_CYCLES + 1) begin
          m_level = ~m_level;
          m_run   = 0;
          m_hold  = 0;
        end else if (m_level) begin
          m_hold++;
        end
      end else begin
        m_run = 0;
        if (m_level) m_hold++;
      end
      m_long = m_level && (m_hold >= HOLD_CYCLES);
    end
  end

  always @(negedge clk) begin
    check("model_level", btn_level, m_level);
    check("model_long", long_press, m_long);
  end

  // Advance n rising edges, then settle 2 time units past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic expect_out(input string name, input logic lvl, input logic lng);
    check({name, "_level"}, btn_level, lvl);
    check({name, "_long"}, long_press, lng);
  endtask

  logic seen_high;
  logic bounce_pat [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

  initial begin
    rst = 1'b1;
    btn_raw = 1'b0;
    tick(3);
    expect_out("in_reset", 1'b0, 1'b0);
    rst = 1'b0;
    tick(3);
    expect_out("idle", 1'b0, 1'b0);

    // Clean press held into a long press; level rises on E7, long on E17.
    btn_raw = 1'b1;
    tick(6);
    expect_out("press_e6", 1'b0, 1'b0);
    tick(1);
    expect_out("press_e7", 1'b1, 1'b0);
    tick(9);
    expect_out("press_e16", 1'b1, 1'b0);
    tick(1);
    expect_out("press_e17", 1'b1, 1'b1);
    tick(50);
    expect_out("long_sat", 1'b1, 1'b1);

    // Clean release: both outputs fall together seven edges after sampling.
    btn_raw = 1'b0;
    tick(6);
    expect_out("release_e6", 1'b1, 1'b1);
    tick(1);
    expect_out("release_e7", 1'b0, 1'b0);
    tick(10);

    // Two-cycle toggling, then a three-cycle pulse: neither may commit.
    seen_high = 1'b0;
    foreach (bounce_pat[i]) begin
      btn_raw = bounce_pat[i];
      tick(1);
      seen_high |= btn_level;
    end
    btn_raw = 1'b0;
    repeat (10) begin tick(1); seen_high |= btn_level; end
    check("bounce_toggle", seen_high, 1'b0);

    seen_high = 1'b0;
    btn_raw = 1'b1;
    repeat (3) begin tick(1); seen_high |= btn_level; end
    btn_raw = 1'b0;
    repeat (10) begin tick(1); seen_high |= btn_level; end
    check("bounce_pulse3", seen_high, 1'b0);

    // Stable press after the bounces commits normally (edge P = E7).
    btn_raw = 1'b1;
    tick(6);
    expect_out("stable_e6", 1'b0, 1'b0);
    tick(1);
    expect_out("stable_e7", 1'b1, 1'b0);

    // Two-cycle release bounce while pressed; long press still due at P+10.
    tick(1);
    btn_raw = 1'b0;
    tick(2);
    btn_raw = 1'b1;
    seen_high = 1'b1;
    repeat (6) begin tick(1); seen_high &= btn_level; end
    check("rel_bounce_level", seen_high, 1'b1);
    expect_out("rel_bounce_p9", 1'b1, 1'b0);
    tick(1);
    expect_out("rel_bounce_p10", 1'b1, 1'b1);

    btn_raw = 1'b0;
    tick(7);
    expect_out("release2_e7", 1'b0, 1'b0);
    tick(10);

    // Reset while the press candidate has cnt=2; window restarts from scratch.
    btn_raw = 1'b1;
    tick(5);
    rst = 1'b1;
    #1;
    expect_out("rst_wait_p", 1'b0, 1'b0);
    tick(1);
    expect_out("rst_wait_p_held", 1'b0, 1'b0);
    rst = 1'b0;
    tick(6);
    expect_out("after_rst_r6", 1'b0, 1'b0);
    tick(1);
    expect_out("after_rst_r7", 1'b1, 1'b0);
    tick(10);
    expect_out("after_rst_long", 1'b1, 1'b1);

    // Asynchronous reset mid-clock while pressed and long-pressed.
    rst = 1'b1;
    #1;
    expect_out("rst_async", 1'b0, 1'b0);
    tick(3);
    expect_out("rst_async_held", 1'b0, 1'b0);
    rst = 1'b0;
    btn_raw = 1'b0;
    tick(10);
    expect_out("final_idle", 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
